// File: rtl/sum_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package sum_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_N = 8;

endpackage

// File: rtl/sum_serial_fa.sv
// 1-bit full-adder cell; the single combinational stage reused for every bit.
module sum_serial_fa (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Ci;
    assign Cout = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/sum_serial.sv
// Bit-serial N-bit adder: latches operands on start, feeds one bit pair per clock
// LSB first through a single full-adder cell, and registers the completed sum.
module sum_serial
    import sum_serial_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  opa;
    logic [N-1:0]  opb;
    logic [N-1:0]  sr;
    logic [N-1:0]  sr_nx;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          st_s;
    logic          st_co;
    logic          last;

    sum_serial_fa u_fa (
        .A    (opa[0]),
        .B    (opb[0]),
        .Ci   (carry),
        .S    (st_s),
        .Cout (st_co)
    );

    assign last = (cnt == LAST);

    // Shift then overwrite the MSB so the same expression also works for N=1.
    always_comb begin
        sr_nx        = sr >> 1;
        sr_nx[N-1]   = st_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            sr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= ci;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    carry <= st_co;
                    sr    <= sr_nx;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        s    <= sr_nx;
                        cout <= st_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sum_serial.sv
// Randomized and directed checks of sum_serial at N=8 and N=1 against an arithmetic model.
module tb_sum_serial;

    logic       clk;
    logic       rst_n;
    logic       start8;
    logic       start1;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy8, done8, cout8;
    logic [7:0] s8;
    logic       busy1, done1, cout1;
    logic       s1;

    int n_checks = 0;
    int n_pass   = 0;
    int acc8 = 0, acc1 = 0;
    int nd8  = 0, nd1  = 0;

    sum_serial #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a), .b(b), .ci(ci),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8)
    );

    sum_serial #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a[0]), .b(b[0]), .ci(ci),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done8) nd8++;
        if (done1) nd1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [8:0] cur_res(input bit sel);
        return sel ? {7'b0, cout1, s1} : {cout8, s8};
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy1 : busy8;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done1 : done8;
    endfunction

    // scr: 0 keep operands, 1 zero them during RUN, 2 randomize them during RUN
    task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic civ, input int scr, input bit hold);
        int unsigned w;
        logic [8:0] exp, prev;
        int lat, bcnt;
        bit seen, holdbad;
        w = sel ? 1 : 8;
        exp = sel ? (9'(av[0]) + 9'(bv[0]) + 9'(civ))
                  : ({1'b0, av} + {1'b0, bv} + 9'(civ));
        seen = 0; holdbad = 0; lat = 0; bcnt = 0;
        @(negedge clk);
        a = av; b = bv; ci = civ;
        if (sel) start1 = 1'b1; else start8 = 1'b1;
        prev = cur_res(sel);
        if (sel) acc1++; else acc8++;
        @(negedge clk);
        if (!hold) begin
            start8 = 1'b0;
            start1 = 1'b0;
        end
        if (scr == 1) begin a = '0; b = '0; ci = 1'b0; end
        if (scr == 2) begin a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); end
        for (int k = 1; k <= 40; k++) begin
            if (cur_done(sel)) begin
                seen = 1;
                lat  = k - 1;
                break;
            end
            if (cur_busy(sel)) bcnt++;
            if (cur_res(sel) !== prev) holdbad = 1;
            @(negedge clk);
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), w);
        check("busy_cycles", 32'(bcnt), w);
        check("result_hold", 32'(holdbad), 32'd0);
        check("sum", 32'(cur_res(sel)), 32'(exp));
        @(negedge clk);
        check("done_pulse_end", 32'(cur_done(sel)), 32'd0);
        check("idle_after_done", 32'(cur_busy(sel)), 32'd0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_s", 32'(s8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        rst_n = 1'b1;

        run_op(0, 8'h3C, 8'h5A, 1'b0, 0, 0);
        check("s_3c5a", 32'(s8), 32'h96);
        run_op(0, 8'h10, 8'h10, 1'b0, 0, 0);
        check("s_1010", 32'(s8), 32'h20);
        run_op(0, 8'hFF, 8'h01, 1'b0, 0, 0);
        check("cout_ff01", 32'(cout8), 32'd1);
        run_op(0, 8'hFF, 8'hFF, 1'b1, 0, 0);
        check("s_ffff1", 32'(s8), 32'hFF);

        // start held high with operands zeroed mid-run; re-accept one IDLE cycle after DONE
        run_op(0, 8'h12, 8'h34, 1'b0, 1, 1);
        check("held_result", 32'(s8), 32'h46);
        acc8++;
        @(negedge clk);
        check("held_accept", 32'(busy8), 32'd1);
        start8 = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done8) begin seen = 1; break; end
            @(negedge clk);
        end
        check("held_done", 32'(seen), 32'd1);
        check("held_sum", 32'({cout8, s8}), 32'h0);
        @(negedge clk);

        run_op(0, 8'h77, 8'h11, 1'b0, 0, 0);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; ci = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_s", 32'(s8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op(0, 8'h01, 8'h01, 1'b0, 0, 0);
        check("s_0101", 32'(s8), 32'h02);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 2, 0);
        end
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 2, 0);
        end

        check("done_count8", 32'(nd8), 32'(acc8));
        check("done_count1", 32'(nd1), 32'(acc1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
